// File: rtl/key_sequence_player.sv
// rtl/key_sequence_player.sv - plays the fixed 7-note unlock sequence onto the live-key bus
//
// Purpose: on start_pulse_i, presses each stored key for NOTE_ON_CYCLES, then releases it
// for GAP_CYCLES. A gap follows every note, so a repeated ID still reads as a new press.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start_pulse_i      one-cycle request to play; ignored while busy
//   abort_i            level; forces idle on the next edge, wins over start
//   key_id_o[3:0]      played key (1-12), 0 when no key is held
//   key_pressed_o      high while a played key is held
//   busy_o             high outside IDLE
//   note_index_o[2:0]  index of the note in PRESS/GAP, 0 in IDLE
//   done_pulse_o       one-cycle pulse in the first IDLE cycle after normal completion
module key_sequence_player #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int NOTE_ON_MS  = 400,
    parameter int GAP_MS      = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_pulse_i,
    input  logic       abort_i,
    output logic [3:0] key_id_o,
    output logic       key_pressed_o,
    output logic       busy_o,
    output logic [2:0] note_index_o,
    output logic       done_pulse_o
);

    localparam int NOTE_ON_CYCLES = NOTE_ON_MS * (CLK_FREQ_HZ / 1000);
    localparam int GAP_CYCLES     = GAP_MS * (CLK_FREQ_HZ / 1000);
    localparam int MAX_A          = (NOTE_ON_CYCLES > GAP_CYCLES) ? NOTE_ON_CYCLES : GAP_CYCLES;
    localparam int MAX_CYCLES     = (MAX_A > 2) ? MAX_A : 2;
    localparam int CW             = $clog2(MAX_CYCLES);
    localparam logic [2:0] LAST_IDX = 3'd6;

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;

    logic [3:0]    key_id_q, key_id_d;
    logic          key_pressed_q, key_pressed_d;
    logic          busy_q, busy_d;
    logic [2:0]    note_index_q, note_index_d;
    logic          done_q, done_d;

    function automatic logic [3:0] seq_key(input logic [2:0] i);
        case (i)
            3'd0:    seq_key = 4'd2;
            3'd1:    seq_key = 4'd3;
            3'd2:    seq_key = 4'd1;
            3'd3:    seq_key = 4'd7;
            3'd4:    seq_key = 4'd6;
            3'd5:    seq_key = 4'd1;
            3'd6:    seq_key = 4'd6;
            default: seq_key = 4'd0;
        endcase
    endfunction

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            key_id_q      <= '0;
            key_pressed_q <= 1'b0;
            busy_q        <= 1'b0;
            note_index_q  <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            key_id_q      <= key_id_d;
            key_pressed_q <= key_pressed_d;
            busy_q        <= busy_d;
            note_index_q  <= note_index_d;
            done_q        <= done_d;
        end
    end

    // Next-state: counter runs 0..N-1 within each phase and is cleared on every phase change,
    // so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_pulse_i) begin
                        state_d = PRESS;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end
                PRESS: begin
                    if (cnt_q == CW'(NOTE_ON_CYCLES - 1)) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        cnt_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = IDLE;
                            idx_d   = '0;
                        end else begin
                            state_d = PRESS;
                            idx_d   = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        key_id_d      = (state_d == PRESS) ? seq_key(idx_d) : 4'd0;
        key_pressed_d = (state_d == PRESS);
        busy_d        = (state_d != IDLE);
        note_index_d  = idx_d;
        // Only a natural GAP->IDLE exit counts as completion; abort takes the other branch.
        done_d        = !abort_i && (state_q == GAP) && (state_d == IDLE);
    end

    assign key_id_o      = key_id_q;
    assign key_pressed_o = key_pressed_q;
    assign busy_o        = busy_q;
    assign note_index_o  = note_index_q;
    assign done_pulse_o  = done_q;

endmodule

// File: tb/tb_key_sequence_player.sv
// tb/tb_key_sequence_player.sv - scoreboard bench for key_sequence_player (4/2 cycle timing)
module tb_key_sequence_player;

    logic       clk;
    logic       rst;
    logic       start_pulse_i;
    logic       abort_i;
    logic [3:0] key_id_o;
    logic       key_pressed_o;
    logic       busy_o;
    logic [2:0] note_index_o;
    logic       done_pulse_o;

    key_sequence_player #(
        .CLK_FREQ_HZ(1000),
        .NOTE_ON_MS (4),
        .GAP_MS     (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_pulse_i(start_pulse_i),
        .abort_i      (abort_i),
        .key_id_o     (key_id_o),
        .key_pressed_o(key_pressed_o),
        .busy_o       (busy_o),
        .note_index_o (note_index_o),
        .done_pulse_o (done_pulse_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Cycles into playback: 0 = idle, 1..42 = busy; each note spans 6 cycles (4 press, 2 gap).
    int t = 0;
    logic [3:0] seqtab [7] = '{4'd2, 4'd3, 4'd1, 4'd7, 4'd6, 4'd1, 4'd6};
    logic [9:0] exp_q [$];

    function automatic logic [9:0] obs_vec();
        return {key_id_o, key_pressed_o, busy_o, note_index_o, done_pulse_o};
    endfunction

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (key,pressed,busy,idx,done)", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, push the outputs expected after the edge, then pop and compare.
    task automatic step(input logic st, input logic ab, input string tag);
        int tn;
        logic done_e;
        logic busy_e;
        logic pr_e;
        int note;
        logic [3:0] key_e;
        logic [2:0] idx_e;
        start_pulse_i = st;
        abort_i       = ab;
        done_e = 1'b0;
        if (ab)           tn = 0;
        else if (t == 0)  tn = st ? 1 : 0;
        else if (t == 42) begin tn = 0; done_e = 1'b1; end
        else              tn = t + 1;
        busy_e = (tn != 0);
        note   = busy_e ? (tn - 1) / 6 : 0;
        pr_e   = busy_e && (((tn - 1) % 6) < 4);
        key_e  = pr_e ? seqtab[note] : 4'd0;
        idx_e  = 3'(note);
        exp_q.push_back({key_e, pr_e, busy_e, idx_e, done_e});
        t = tn;
        @(posedge clk);
        #1;
        check(tag, obs_vec(), exp_q.pop_front());
    endtask

    task automatic idle_steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, tag);
    endtask

    initial begin
        rst = 1'b1;
        start_pulse_i = 1'b0;
        abort_i = 1'b0;
        #12;
        check("reset_outputs", obs_vec(), 10'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_idle", obs_vec(), 10'b0);

        // Full playback: done in cycle 43 only, then idle.
        step(1'b1, 1'b0, "full_start");
        idle_steps(45, "full_play");

        // Restart attempt at cycle 10 is ignored.
        step(1'b1, 1'b0, "restart_start");
        idle_steps(9, "restart_pre");
        step(1'b1, 1'b0, "restart_ignored");
        idle_steps(35, "restart_play");

        // Abort at cycle 20.
        step(1'b1, 1'b0, "abort_start");
        idle_steps(19, "abort_pre");
        step(1'b0, 1'b1, "abort_cycle");
        idle_steps(25, "abort_after");

        // Abort wins over start in IDLE; start alone next cycle plays.
        step(1'b1, 1'b1, "abort_vs_start");
        step(1'b1, 1'b0, "start_after_abort");
        idle_steps(3, "start_after_abort_play");
        step(1'b0, 1'b1, "abort_cleanup");
        idle_steps(2, "abort_cleanup_idle");

        // Async reset mid-PRESS of note 3 (t=20 is inside cycles 19..22).
        step(1'b1, 1'b0, "rst_start");
        idle_steps(19, "rst_pre");
        check("rst_pre_note3", {key_id_o, key_pressed_o, note_index_o}, {4'd7, 1'b1, 3'd3});
        #2 rst = 1'b1;
        #1;
        check("rst_async_zero", obs_vec(), 10'b0);
        #2 rst = 1'b0;
        t = 0;
        @(posedge clk);
        #1;
        check("rst_released_idle", obs_vec(), 10'b0);
        idle_steps(3, "rst_wait_idle");
        step(1'b1, 1'b0, "rst_fresh_start");
        idle_steps(44, "rst_fresh_play");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_sequence_player.md
KEY_SEQUENCE_PLAYER -- requirements
Module: key_sequence_player

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50_000_000, clock frequency in Hz.
REQ-002 Parameter NOTE_ON_MS, default 400, press duration of each note in ms.
REQ-003 Parameter GAP_MS, default 100, release gap after each note in ms.
REQ-004 clk  input  1  system clock; one clock, all logic on rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 start_pulse  input  1  one-cycle request to play the stored sequence.
REQ-007 abort  input  1  level; stops playback immediately while high.
REQ-008 key_id  output  4  played key ID: 1-12 note, 0 none; same encoding as the live-key bus it drives.
REQ-009 key_pressed  output  1  high while a played key is held.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 note_index  output  3  index (0-6) of the note currently in PRESS or GAP; 0 in IDLE.
REQ-012 done_pulse  output  1  single-cycle pulse on normal completion.

Function
REQ-013 Derived constants SHALL be NOTE_ON_CYCLES = NOTE_ON_MS*(CLK_FREQ_HZ/1000) and GAP_CYCLES = GAP_MS*(CLK_FREQ_HZ/1000); both SHALL be >= 1.
REQ-014 The stored sequence SHALL be the 7-entry constant 2,3,1,7,6,1,6 (index 0 first), matching the practice-mode unlock sequence.
REQ-015 The duration counter SHALL be sized by $clog2 of max(NOTE_ON_CYCLES, GAP_CYCLES, 2) and SHALL never wrap.
REQ-016 States SHALL be IDLE, PRESS, GAP; all outputs SHALL be registered.
REQ-017 IDLE: key_id=0, key_pressed=0, busy=0, note_index=0; start_pulse high (abort low) SHALL enter PRESS with note_index=0 on the next edge.
REQ-018 PRESS: key_id=sequence[note_index], key_pressed=1, for exactly NOTE_ON_CYCLES cycles, then GAP.
REQ-019 GAP: key_id=0, key_pressed=0, for exactly GAP_CYCLES cycles; a gap SHALL follow every note, so consecutive equal IDs are seen as separate presses by the detector.
REQ-020 End of GAP with note_index<6 SHALL increment note_index and enter PRESS; with note_index=6 SHALL enter IDLE and assert done_pulse in that first IDLE cycle only.
REQ-021 Latency: first PRESS cycle SHALL be the cycle after start_pulse is sampled; total busy time SHALL be 7*(NOTE_ON_CYCLES+GAP_CYCLES) cycles.
REQ-022 start_pulse while busy SHALL be ignored (no restart, no counter reset).
REQ-023 abort high in any state SHALL force IDLE outputs on the next edge, clear counter and note_index, and SHALL NOT assert done_pulse.
REQ-024 abort and start_pulse high in the same IDLE cycle: abort SHALL win; remain IDLE.
REQ-025 done_pulse SHALL be 0 in every cycle except that defined in REQ-020.

Reset
REQ-026 rst high SHALL asynchronously force IDLE, counter=0, key_id=0, key_pressed=0, busy=0, note_index=0, done_pulse=0.
REQ-027 rst asserted mid-playback SHALL abandon the sequence; after release the block SHALL wait in IDLE for a new start_pulse.

Verification (bench parameters CLK_FREQ_HZ=1000, NOTE_ON_MS=4, GAP_MS=2 -> 4 and 2 cycles)
REQ-028 start_pulse at cycle 0 -> key_pressed high cycles 1-4 with key_id=2, low cycles 5-6, key_id=3 cycles 7-10, ..., last key_id=6 cycles 37-40, done_pulse at cycle 43 only, busy cycles 1-42.
REQ-029 Player output wired to mode_sequencer (TIMEOUT satisfied) -> practice_mode_active_pulse exactly once, during last note's PRESS.
REQ-030 start_pulse again at cycle 10 during playback -> waveform identical to REQ-028.
REQ-031 abort at cycle 20 -> cycle 21 key_pressed=0, key_id=0, busy=0, note_index=0; no done_pulse.
REQ-032 start_pulse and abort together in IDLE -> busy stays 0; start_pulse alone next cycle -> PRESS following cycle with key_id=2.
REQ-033 rst pulsed asynchronously mid-PRESS of note 3 -> all outputs 0 immediately; no done_pulse; fresh start replays from key_id=2.
